// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Multi-cycle instruction sequencer for the accumulator core. One instruction
// (TypeBit + OP) is accepted per handshake. All control strobes are registered,
// so they appear the cycle after acceptance. Memory instructions (lw/sw)
// occupy MEM_LAT cycles and stall the fetch stage on all but their final
// cycle. Halt (OP 15) parks the block in HALTED until Resume. Opcodes >= 16
// with TypeBit = 1 set a sticky Illegal flag.
//
// Parameters:
//   OP_W     opcode width (>= 4); encodings >= 16 are illegal
//   MEM_LAT  cycles occupied by lw/sw (>= 1)
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   synchronous active-low reset
//   InstValid  in   instruction on TypeBit/OP is valid
//   TypeBit    in   0 = geti (OP ignored), 1 = register form
//   OP         in   opcode [OP_W-1:0]
//   Resume     in   leave HALTED
//   RWrite, AWrite, Branch, LookUp,
//   ReadMem, WriteMem, isMem, OvfClr  out  registered control strobes
//   Halt       out  high while HALTED
//   Stall      out  upstream must hold instruction and PC
//   InstDone   out  pulse on the final cycle of each accepted instruction
//   Illegal    out  sticky illegal-opcode flag
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int OP_W    = 4,
    parameter int MEM_LAT = 2
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            InstValid,
    input  logic            TypeBit,
    input  logic [OP_W-1:0] OP,
    input  logic            Resume,
    output logic            RWrite,
    output logic            AWrite,
    output logic            Branch,
    output logic            LookUp,
    output logic            ReadMem,
    output logic            WriteMem,
    output logic            isMem,
    output logic            OvfClr,
    output logic            Halt,
    output logic            Stall,
    output logic            InstDone,
    output logic            Illegal
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_HALTED
    } state_t;

    typedef struct packed {
        logic rwrite;
        logic awrite;
        logic branch;
        logic lookup;
        logic read_mem;
        logic write_mem;
        logic is_mem;
        logic ovf_clr;
        logic halt;
        logic stall;
        logic inst_done;
    } ctrl_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             is_lw_q,   is_lw_d;
    logic             illegal_q, illegal_d;
    ctrl_t            ctrl_q,    ctrl_d;

    logic accept;
    logic op_illegal;

    // Only the bits above the 4-bit defined range can make an opcode illegal.
    if (OP_W > 4) begin : g_wide_op
        assign op_illegal = |OP[OP_W-1:4];
    end else begin : g_narrow_op
        assign op_illegal = 1'b0;
    end

    // Stall is the registered output, so acceptance never depends
    // combinationally on this cycle's decode.
    assign accept = InstValid && !ctrl_q.stall && (state_q != S_HALTED);

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_lw_d   = is_lw_q;
        illegal_d = illegal_q;
        ctrl_d    = '0;

        unique case (state_q)
            S_IDLE: ;
            S_MEM: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALTED: begin
                if (Resume) begin
                    state_d = S_IDLE;
                end else begin
                    ctrl_d.halt  = 1'b1;
                    ctrl_d.stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accept is possible in IDLE and on the final MEM cycle (back-to-back).
        if (accept) begin
            ctrl_d.inst_done = 1'b1;
            if (!TypeBit) begin
                ctrl_d.awrite = 1'b1;
            end else if (op_illegal) begin
                illegal_d = 1'b1;
            end else begin
                unique case (OP[3:0])
                    4'd0, 4'd4, 4'd5, 4'd9, 4'd10,
                    4'd11, 4'd12, 4'd13, 4'd14: ctrl_d.awrite = 1'b1;
                    4'd1:       ctrl_d.rwrite = 1'b1;
                    4'd2, 4'd3: begin
                        state_d          = S_MEM;
                        cnt_d            = CNT_LOAD;
                        is_lw_d          = (OP[3:0] == 4'd2);
                        ctrl_d.inst_done = 1'b0;
                    end
                    4'd6:       ctrl_d.ovf_clr = 1'b1;
                    4'd7, 4'd8: begin
                        ctrl_d.branch = 1'b1;
                        ctrl_d.lookup = 1'b1;
                    end
                    4'd15: begin
                        state_d      = S_HALTED;
                        ctrl_d.halt  = 1'b1;
                        ctrl_d.stall = 1'b1;
                    end
                endcase
            end
        end

        // MEM-cycle strobes follow from the next state and count, covering
        // both the first MEM cycle and the later ones in one place.
        if (state_d == S_MEM) begin
            ctrl_d.read_mem  = is_lw_d;
            ctrl_d.is_mem    = is_lw_d;
            ctrl_d.write_mem = !is_lw_d;
            ctrl_d.stall     = (cnt_d != '0);
            ctrl_d.inst_done = (cnt_d == '0);
            ctrl_d.awrite    = is_lw_d && (cnt_d == '0);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_lw_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_lw_q   <= is_lw_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign RWrite   = ctrl_q.rwrite;
    assign AWrite   = ctrl_q.awrite;
    assign Branch   = ctrl_q.branch;
    assign LookUp   = ctrl_q.lookup;
    assign ReadMem  = ctrl_q.read_mem;
    assign WriteMem = ctrl_q.write_mem;
    assign isMem    = ctrl_q.is_mem;
    assign OvfClr   = ctrl_q.ovf_clr;
    assign Halt     = ctrl_q.halt;
    assign Stall    = ctrl_q.stall;
    assign InstDone = ctrl_q.inst_done;
    assign Illegal  = illegal_q;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle successor to the single-cycle opcode decoder in the accumulator core. It accepts one instruction (TypeBit + OP) per handshake and drives registered control strobes. It stretches memory instructions over a parametrised number of wait cycles and stalls the fetch stage during them. It latches halt until an explicit resume and flags illegal opcodes when the opcode field is widened beyond 4 bits.

## Interface
- OP_W, 4: opcode width, must be ≥ 4; encodings 0–15 are defined, ≥ 16 are illegal.
- MEM_LAT, 2: cycles a lw/sw occupies, must be ≥ 1.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- InstValid  in  1  instruction on TypeBit/OP is valid.
- TypeBit  in  1  0 = geti (immediate form; OP ignored), 1 = register form.
- OP  in  OP_W  opcode.
- Resume  in  1  leave HALTED.
- RWrite, AWrite, Branch, LookUp, ReadMem, WriteMem, isMem, OvfClr  out  1 each  registered control strobes.
- Halt  out  1  high for the whole time the block is in HALTED.
- Stall  out  1  upstream holds the instruction and PC.
- InstDone  out  1  one-cycle pulse on the final cycle of every accepted instruction.
- Illegal  out  1  sticky illegal-opcode flag.

## Operation
- States: IDLE, MEM, HALTED. Counter width is clog2(MEM_LAT+1).
- Accept condition: InstValid && !Stall && state != HALTED. Decode is registered, so strobes appear the cycle after acceptance.
- Decode when TypeBit = 1:
  - 0 get: AWrite.
  - 1 set: RWrite.
  - 2 lw: ReadMem, isMem, AWrite (AWrite on the final MEM cycle only).
  - 3 sw: WriteMem.
  - 4, 5, 9–14 (ALU/compare/shift/parse): AWrite.
  - 6: OvfClr.
  - 7, 8 (bt/bf): Branch, LookUp.
  - 15: enter HALTED.
- TypeBit = 0 always decodes as geti (AWrite only), regardless of OP. This applies even when OP ≥ 16.
- OP ≥ 16 with TypeBit = 1: no strobes, InstDone pulses, Illegal is set and stays set until reset.
- Single-cycle ops: strobes high for exactly one cycle with InstDone; state stays IDLE.
- lw/sw: state goes to MEM and the counter loads MEM_LAT-1.
  - ReadMem/WriteMem and isMem (lw only) are high on every MEM cycle.
  - Counter decrements each cycle; the final cycle is the one where count = 0.
  - Stall is high on every MEM cycle except the final one.
  - The final cycle carries InstDone (and AWrite for lw); the next state is IDLE.
  - A new instruction can be accepted on the final cycle, giving back-to-back issue.
- Halt (OP 15): next state is HALTED.
  - Halt and Stall are held high; all other strobes are 0.
  - InstDone pulses on the first HALTED cycle only.
  - InstValid is ignored while HALTED.
  - Resume high moves to IDLE on the next edge, where Halt and Stall drop.
- MEM_LAT = 1: lw/sw complete in one cycle with no Stall; the MEM state is still used for that cycle.

## Timing
- Reset (Reset_n = 0 at an edge): state IDLE, counter 0, all outputs 0 including Illegal, Halt and Stall.
- Reset mid-MEM or mid-HALTED aborts the operation; outputs are 0 at the following edge.
- Latency from accept to first strobe is 1 cycle.
- lw/sw occupy exactly MEM_LAT cycles; every other instruction occupies 1 cycle.
- Throughput is one instruction per cycle for non-memory ops. A memory op followed by any op costs MEM_LAT cycles.
- All outputs are registered; none depends combinationally on the inputs.
- Resume asserted in a non-HALTED state has no effect.
- Resume and Reset_n = 0 together: reset wins.

## Test plan
- Reset, then issue TypeBit = 1 with OP = 0..14 on consecutive cycles (skip 2, 3). Each strobe pattern matches the decode list exactly one cycle after issue; InstDone pulses every cycle; Stall stays 0.
- MEM_LAT = 3, lw, then add issued immediately. ReadMem/isMem high for 3 cycles and Stall high for the first 2. AWrite and InstDone occur on cycle 3 only. Add's AWrite appears on cycle 4.
- MEM_LAT = 1, sw then sw: WriteMem high for 2 consecutive cycles, Stall never asserts.
- OP = 15, then InstValid held high for 5 cycles, then Resume. Halt and Stall stay high with no other strobes; both drop one cycle after Resume; the next instruction is accepted.
- OP_W = 5: OP = 20 with TypeBit = 1 gives no strobes, InstDone, and Illegal = 1 persisting. OP = 20 with TypeBit = 0 gives only AWrite.
- Reset_n = 0 on cycle 2 of a MEM_LAT = 4 lw: all outputs 0 next cycle and state IDLE. A subsequent get behaves normally.
